seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Unsigned radix-2 restoring sequential divider. It is the inverse-operation counterpart to the team's sequential multiplier.
- Computes quotient and remainder of two WIDTH-bit operands, one bit per clock.
- Each trial subtraction runs on a carry look-ahead subtractor.
- Sits beside the multiplier in the arithmetic datapath and uses the same start/clear/done control style.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (must be ≥2).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
op_start  input  1  start request, sampled only in IDLE or DONE
op_clear  input  1  synchronous clear to IDLE, highest priority after reset
dividend  input  WIDTH  unsigned dividend, sampled with op_start
divisor  input  WIDTH  unsigned divisor, sampled with op_start
quotient  output  WIDTH  result quotient, valid while op_done=1
remainder  output  WIDTH  result remainder, valid while op_done=1
busy  output  1  high while in EXEC
op_done  output  1  high while in DONE
div_by_zero  output  1  high in DONE when the sampled divisor was 0

Behaviour:
- One clock: clk. Reset is asynchronous and active-low: reset_n.
- Reset (reset_n=0, asynchronous):
  - state=IDLE
  - quotient, remainder, internal registers and counter = 0
  - busy=op_done=div_by_zero=0
- States: IDLE, EXEC, DONE. All outputs are registered or decoded from the state register; no combinational input-to-output path.
- Priority at each edge: op_clear > op_start > normal progress.
- op_clear=1 in any state:
  - next state IDLE
  - all data registers and flags cleared to 0
  - any operation in progress is abandoned
- IDLE or DONE with op_start=1, divisor≠0:
  - load R=0 (WIDTH+1 bits), Q=dividend, D=divisor, cnt=0
  - clear div_by_zero
  - go to EXEC
- IDLE or DONE with op_start=1, divisor=0:
  - go directly to DONE on that edge
  - quotient = all ones, remainder = dividend, div_by_zero=1
- EXEC iteration, one per edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D}, computed (WIDTH+1) bits wide on the subtractor
  - if T[WIDTH]=0: R←T, qbit=1; else R←{R[WIDTH-1:0], Q[WIDTH-1]}, qbit=0
  - Q←{Q[WIDTH-2:0], qbit}; cnt←cnt+1
  - when cnt=WIDTH−1, this final iteration also moves the state to DONE and copies Q→quotient and R[WIDTH-1:0]→remainder
- Latency:
  - divisor≠0: the start edge plus WIDTH EXEC edges; op_done rises after edge WIDTH+1 counted from and including the start edge (33 edges for WIDTH=32)
  - divisor=0: op_done after 1 edge
- op_start during EXEC is ignored; operands are not re-sampled.
- Operand inputs may change freely after the start edge.
- DONE holds its outputs indefinitely until op_clear or a new op_start.
- op_start in DONE starts a new operation: op_done falls on that same edge, and quotient/remainder keep their old values until the new result is written.
- Counter width is clog2(WIDTH)+1. It wraps only by re-load, never by overflow.
- Edge cases that must be exact:
  - dividend<divisor → quotient 0, remainder = dividend
  - divisor=1 → quotient = dividend, remainder 0

Decomposition:
- Shared package/include holds the state encodings (IDLE=2'b00, EXEC=2'b01, DONE=2'b10) and the counter-width function.
- One sub-module: cla_sub, a (WIDTH+1)-bit subtractor.
  - Built from 4-bit carry look-ahead slices with a = minuend, b = ~subtrahend, ci=1.
  - Exposes difference and borrow-out.
  - (WIDTH+1) is rounded up to a multiple of 4 internally, with zero padding.

Test Plan:
1. WIDTH=32, dividend=100, divisor=7, op_start 1 cycle → op_done after 33 edges; quotient=14, remainder=2, div_by_zero=0; busy high for exactly 32 cycles.
2. dividend=0xFFFFFFFF, divisor=1 → quotient=0xFFFFFFFF, remainder=0. Then dividend=0xFFFFFFFF, divisor=0xFFFFFFFF → quotient=1, remainder=0.
3. dividend=5, divisor=9 → quotient=0, remainder=5. Then dividend=0, divisor=3 → quotient=0, remainder=0.
4. dividend=1234, divisor=0 → op_done and div_by_zero after 1 edge; quotient=0xFFFFFFFF, remainder=1234; busy never asserts.
5. Start 1000/10, pulse op_start with 50/5 at EXEC cycle 10 → pulse ignored, result quotient=100, remainder=0. In DONE, start 50/5 → new result quotient=10, remainder=0 after 33 edges.
6. Assert op_clear at EXEC cycle 16 → next edge IDLE, all outputs 0. Separately, drop reset_n mid-EXEC asynchronously → outputs 0 immediately, no op_done after release.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: the state encoding and the
// iteration-counter width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_cla_sub.sv
// WIDTH-bit subtractor, minuend - subtrahend, built from 4-bit carry look-ahead
// slices rippling between slices. borrow is high when subtrahend > minuend.
module cla_sub #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);

    localparam int SLICES = (WIDTH + 3) / 4;
    localparam int PAD_W  = SLICES * 4;

    logic [PAD_W-1:0] a_pad;
    logic [PAD_W-1:0] b_pad;
    logic [PAD_W-1:0] sum_pad;

    // Pad bits become a=0, b=1 after inversion, so the final carry propagates
    // unchanged through the padding and the last slice's carry-out is the result.
    assign a_pad = PAD_W'(minuend);
    assign b_pad = ~(PAD_W'(subtrahend));

    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : slice
            logic       ci;
            logic [3:0] g;
            logic [3:0] p;
            logic [4:0] cv;

            if (gi == 0) begin : g_first
                assign ci = 1'b1;
            end else begin : g_chain
                assign ci = slice[gi-1].cv[4];
            end

            assign g = a_pad[4*gi +: 4] & b_pad[4*gi +: 4];
            assign p = a_pad[4*gi +: 4] ^ b_pad[4*gi +: 4];

            assign cv[0] = ci;
            assign cv[1] = g[0] | (p[0] & ci);
            assign cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
            assign cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                         | (p[2] & p[1] & p[0] & ci);
            assign cv[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                         | (p[3] & p[2] & p[1] & g[0])
                         | (p[3] & p[2] & p[1] & p[0] & ci);

            assign sum_pad[4*gi +: 4] = p ^ cv[3:0];
        end

        if (PAD_W > WIDTH) begin : g_pad
            logic pad_unused;
            assign pad_unused = ^sum_pad[PAD_W-1:WIDTH];
        end
    endgenerate

    assign difference = sum_pad[WIDTH-1:0];
    assign borrow     = ~slice[SLICES-1].cv[4];

endmodule

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring sequential divider: one quotient bit per clock,
// trial subtraction on a carry look-ahead subtractor, start/clear/done control.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             op_done,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    // After every restoring step R < D, so the top bit of the (WIDTH+1)-bit
    // partial remainder is always zero and is not stored.
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic             diff_msb_unused;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_shift;

    assign trial_a = {r_reg, q_reg[WIDTH-1]};

    cla_sub #(
        .WIDTH (WIDTH + 1)
    ) u_cla_sub (
        .minuend    (trial_a),
        .subtrahend ({1'b0, d_reg}),
        .difference (trial_diff),
        .borrow     (trial_borrow)
    );

    assign diff_msb_unused = trial_diff[WIDTH];
    assign r_step  = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign q_shift = {q_reg[WIDTH-2:0], ~trial_borrow};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            q_reg     <= q_next;
            d_reg     <= d_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_next;
            dbz_reg   <= dbz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        cnt_next   = cnt_reg;
        dbz_next   = dbz_reg;

        if (op_clear) begin
            state_next = IDLE;
            r_next     = '0;
            q_next     = '0;
            d_next     = '0;
            quot_next  = '0;
            rem_next   = '0;
            cnt_next   = '0;
            dbz_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (op_start) begin
                        if (divisor == '0) begin
                            state_next = DONE;
                            quot_next  = '1;
                            rem_next   = dividend;
                            dbz_next   = 1'b1;
                        end else begin
                            state_next = EXEC;
                            r_next     = '0;
                            q_next     = dividend;
                            d_next     = divisor;
                            cnt_next   = '0;
                            dbz_next   = 1'b0;
                        end
                    end
                end
                EXEC: begin
                    r_next   = r_step;
                    q_next   = q_shift;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_next = DONE;
                        quot_next  = q_shift;
                        rem_next   = r_step;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign quotient    = quot_reg;
    assign remainder   = rem_reg;
    assign busy        = (state_reg == EXEC);
    assign op_done     = (state_reg == DONE);
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_start = 1'b0;
    logic         op_clear = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         op_done;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .op_done     (op_done),
        .div_by_zero (div_by_zero)
    );

    // Reference: integer division; divide-by-zero yields all ones / dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = W + 1;
        end
    endfunction

    // Starts an operation and waits (bounded) for op_done; edges counted from the start edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges, output int busy_cycles);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        edges = 1;
        busy_cycles = busy ? 1 : 0;
        while (!op_done && edges < 200) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cycles++;
        end
        $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b edges=%0d", a, b, quotient, remainder,
                 div_by_zero, edges);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({quotient, remainder, busy, op_done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b required all 0",
                     quotient, remainder, busy, op_done, div_by_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({quotient, remainder, busy, op_done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got q=%h r=%h busy=%b done=%b dbz=%b required all 0",
                     quotient, remainder, busy, op_done, div_by_zero);
        end
    endtask

    task automatic test_basic();
        int edges, bc;
        run_op(32'd100, 32'd7, edges, bc);
        checks++;
        if (edges != 33) begin
            errors++; $display("FAIL basic_latency: got %0d required 33", edges);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b required q=14 r=2 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        checks++;
        if (bc != 32) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d required 32", bc);
        end
    endtask

    task automatic test_extremes();
        int edges, bc;
        run_op(32'hFFFF_FFFF, 32'd1, edges, bc);
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
            errors++;
            $display("FAIL div_by_one: got q=%h r=%h required q=ffffffff r=0", quotient, remainder);
        end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, bc);
        checks++;
        if (quotient !== 32'd1 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL max_by_max: got q=%h r=%h required q=1 r=0", quotient, remainder);
        end
    endtask

    task automatic test_small();
        int edges, bc;
        run_op(32'd5, 32'd9, edges, bc);
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd5) begin
            errors++;
            $display("FAIL dividend_lt_divisor: got q=%0d r=%0d required q=0 r=5",
                     quotient, remainder);
        end
        run_op(32'd0, 32'd3, edges, bc);
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL zero_dividend: got q=%0d r=%0d required q=0 r=0", quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        int edges, bc;
        run_op(32'd1234, 32'd0, edges, bc);
        checks++;
        if (edges != 1 || bc != 0) begin
            errors++;
            $display("FAIL dbz_timing: got edges=%0d busy_cycles=%0d required edges=1 busy_cycles=0",
                     edges, bc);
        end
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd1234 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: got q=%h r=%0d dbz=%b required q=ffffffff r=1234 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (op_done !== 1'b1 || div_by_zero !== 1'b1 || remainder !== 32'd1234) begin
            errors++;
            $display("FAIL done_hold: got done=%b dbz=%b r=%0d required done=1 dbz=1 r=1234",
                     op_done, div_by_zero, remainder);
        end
    endtask

    task automatic test_start_ignored();
        int edges;
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd10; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        edges = 1;
        repeat (9) begin @(negedge clk); edges++; end
        dividend = 32'd50; divisor = 32'd5; op_start = 1'b1;
        @(negedge clk);
        edges++;
        op_start = 1'b0;
        while (!op_done && edges < 200) begin @(negedge clk); edges++; end
        $display("op 1000 / 10 (start pulse mid-run) -> q=%0d r=%0d edges=%0d",
                 quotient, remainder, edges);
        checks++;
        if (edges != 33 || quotient !== 32'd100 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL start_ignored: got edges=%0d q=%0d r=%0d required edges=33 q=100 r=0",
                     edges, quotient, remainder);
        end
        dividend = 32'd50; divisor = 32'd5; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        checks++;
        if (op_done !== 1'b0 || busy !== 1'b1 || quotient !== 32'd100) begin
            errors++;
            $display("FAIL restart_from_done: got done=%b busy=%b q=%0d required done=0 busy=1 q=100",
                     op_done, busy, quotient);
        end
        edges = 1;
        while (!op_done && edges < 200) begin @(negedge clk); edges++; end
        $display("op 50 / 5 (restart from DONE) -> q=%0d r=%0d edges=%0d", quotient, remainder, edges);
        checks++;
        if (edges != 33 || quotient !== 32'd10 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL restart_result: got edges=%0d q=%0d r=%0d required edges=33 q=10 r=0",
                     edges, quotient, remainder);
        end
    endtask

    task automatic test_clear();
        int done_seen = 0;
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd10; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (15) @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        $display("op 1000 / 10 cleared at EXEC cycle 16 -> q=%0d r=%0d busy=%b", quotient,
                 remainder, busy);
        checks++;
        if ({quotient, remainder, busy, op_done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL clear_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b required all 0",
                     quotient, remainder, busy, op_done, div_by_zero);
        end
        repeat (40) begin @(negedge clk); if (op_done || busy) done_seen++; end
        checks++;
        if (done_seen != 0) begin
            errors++; $display("FAIL clear_abandons: got %0d active cycles required 0", done_seen);
        end
    endtask

    task automatic test_async_reset();
        int edges, bc;
        int active = 0;
        run_op(32'd77, 32'd5, edges, bc);
        checks++;
        if (quotient !== 32'd15 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL pre_reset_op: got q=%0d r=%0d required q=15 r=2", quotient, remainder);
        end
        @(negedge clk);
        dividend = 32'd999; divisor = 32'd3; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        $display("async reset mid-EXEC -> q=%0d r=%0d busy=%b", quotient, remainder, busy);
        checks++;
        if ({quotient, remainder, busy, op_done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b required all 0",
                     quotient, remainder, busy, op_done, div_by_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) begin @(negedge clk); if (op_done || busy) active++; end
        checks++;
        if (active != 0) begin
            errors++; $display("FAIL post_reset_idle: got %0d active cycles required 0", active);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a, b, eq, er;
            logic ez;
            int elat, edges, bc;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = W'($urandom_range(1, 15));
                1: b = $urandom;
                2: b = (a == '1) ? a : a + W'($urandom_range(1, 1000));
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = '0;
            endcase
            model(a, b, eq, er, ez, elat);
            run_op(a, b, edges, bc);
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez || edges != elat) begin
                errors++;
                $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dbz=%b edges=%0d required q=%0d r=%0d dbz=%b edges=%0d",
                         i, a, b, quotient, remainder, div_by_zero, edges, eq, er, ez, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_small();
        test_div_zero();
        test_start_ignored();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
